// File: rtl/morra_score_monitor.sv
// Score monitor for the MorraCinese FSMD: tallies rounds, logs them into a
// valid/ready FIFO and cross-checks the declared match winner.
module morra_score_monitor #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic             INIZIO,
  input  logic [1:0]       MANCHE,
  input  logic [1:0]       PARTITA,
  output logic [CNT_W-1:0] VINTE1,
  output logic [CNT_W-1:0] VINTE2,
  output logic [CNT_W-1:0] PAREGGI,
  output logic [CNT_W-1:0] GIOCATE,
  output logic             FINE,
  output logic [1:0]       VINCITORE,
  output logic             LOG_VALID,
  output logic [CNT_W+1:0] LOG_DATA,
  input  logic             LOG_READY,
  output logic             OVERFLOW,
  output logic             ERRORE
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GIOCO  = 2'd1,
    FINE_P = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] v1_q, v1_d, v2_q, v2_d, par_q, par_d, gio_q, gio_d;
  logic             fine_q, fine_d;
  logic [1:0]       vinc_q, vinc_d;
  logic             ovf_q, ovf_d, err_q, err_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [CNT_W+1:0] mem_q [DEPTH];
  logic             push_s, pop_s, full_s, wr_en_s;
  logic [CNT_W+1:0] wdata_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] r;
    if (en && (v != CNT_MAX)) r = v + CNT_W'(1);
    else                      r = v;
    return r;
  endfunction

  function automatic logic winner_mismatch(input logic [1:0] res,
                                           input logic [CNT_W-1:0] a,
                                           input logic [CNT_W-1:0] b);
    logic r;
    case (res)
      2'b01:   r = !(a > b);
      2'b10:   r = !(b > a);
      2'b11:   r = (a != b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Next-state, tally, error and FIFO-pointer logic.
  always_comb begin
    state_d  = state_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    par_d    = par_q;
    gio_d    = gio_q;
    fine_d   = 1'b0;
    vinc_d   = vinc_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    push_s   = 1'b0;
    wr_en_s  = 1'b0;
    full_s   = (cnt_q == (AW+1)'(DEPTH));
    pop_s    = (cnt_q != '0) && LOG_READY;
    wdata_s  = '0;

    if (INIZIO) begin
      state_d  = GIOCO;
      v1_d     = '0;
      v2_d     = '0;
      par_d    = '0;
      gio_d    = '0;
      vinc_d   = 2'b00;
      ovf_d    = 1'b0;
      err_d    = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        GIOCO: begin
          if (MANCHE != 2'b00) begin
            v1_d   = sat_inc(v1_q,  MANCHE == 2'b01);
            v2_d   = sat_inc(v2_q,  MANCHE == 2'b10);
            par_d  = sat_inc(par_q, MANCHE == 2'b11);
            gio_d  = sat_inc(gio_q, 1'b1);
            push_s = 1'b1;
          end else begin
            push_s = 1'b0;
          end
          // The winner is judged against tallies that already include this round.
          if (PARTITA != 2'b00) begin
            vinc_d  = PARTITA;
            fine_d  = 1'b1;
            state_d = FINE_P;
            if (winner_mismatch(PARTITA, v1_d, v2_d)) err_d = 1'b1;
            else                                      err_d = err_q;
          end else begin
            state_d = GIOCO;
          end
        end
        IDLE, FINE_P: begin
          if ((MANCHE != 2'b00) || (PARTITA != 2'b00)) err_d = 1'b1;
          else                                         err_d = err_q;
        end
        default: state_d = IDLE;
      endcase

      if ((v1_d == CNT_MAX) || (v2_d == CNT_MAX) || (par_d == CNT_MAX) || (gio_d == CNT_MAX))
        err_d = 1'b1;
      else
        ovf_d = ovf_q;

      wdata_s = {gio_d, MANCHE};
      wr_en_s = push_s && (!full_s || pop_s);
      if (push_s && full_s && !pop_s) ovf_d = 1'b1;
      else                            fine_d = fine_d;

      if (wr_en_s) wr_ptr_d = wr_ptr_q + AW'(1);
      else         wr_ptr_d = wr_ptr_q;
      if (pop_s)   rd_ptr_d = rd_ptr_q + AW'(1);
      else         rd_ptr_d = rd_ptr_q;

      case ({wr_en_s, pop_s})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      v1_q     <= '0;
      v2_q     <= '0;
      par_q    <= '0;
      gio_q    <= '0;
      fine_q   <= 1'b0;
      vinc_q   <= 2'b00;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      par_q    <= par_d;
      gio_q    <= gio_d;
      fine_q   <= fine_d;
      vinc_q   <= vinc_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Log storage; contents are only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (RESET_N && wr_en_s) mem_q[wr_ptr_q] <= wdata_s;
  end

  assign VINTE1    = v1_q;
  assign VINTE2    = v2_q;
  assign PAREGGI   = par_q;
  assign GIOCATE   = gio_q;
  assign FINE      = fine_q;
  assign VINCITORE = vinc_q;
  assign OVERFLOW  = ovf_q;
  assign ERRORE    = err_q;
  assign LOG_VALID = (cnt_q != '0);
  assign LOG_DATA  = LOG_VALID ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_morra_score_monitor.sv
// Bench for morra_score_monitor: behavioural model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_morra_score_monitor;
  localparam int DEPTH = 8;
  localparam int CNT_W = 5;
  localparam int MAXC  = 31;

  logic             clk = 1'b0;
  logic             RESET_N, INIZIO, LOG_READY;
  logic [1:0]       MANCHE, PARTITA;
  logic [CNT_W-1:0] VINTE1, VINTE2, PAREGGI, GIOCATE;
  logic             FINE, LOG_VALID, OVERFLOW, ERRORE;
  logic [1:0]       VINCITORE;
  logic [CNT_W+1:0] LOG_DATA;

  morra_score_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .RESET_N(RESET_N), .INIZIO(INIZIO), .MANCHE(MANCHE), .PARTITA(PARTITA),
    .VINTE1(VINTE1), .VINTE2(VINTE2), .PAREGGI(PAREGGI), .GIOCATE(GIOCATE),
    .FINE(FINE), .VINCITORE(VINCITORE), .LOG_VALID(LOG_VALID), .LOG_DATA(LOG_DATA),
    .LOG_READY(LOG_READY), .OVERFLOW(OVERFLOW), .ERRORE(ERRORE)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  int         m_v1, m_v2, m_par, m_gio;
  bit         m_fine, m_ovf, m_err, in_match;
  logic [1:0] m_vinc;
  logic [6:0] m_q[$];
  logic [6:0] pops[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit rn, input bit ini, input logic [1:0] m,
                              input logic [1:0] p, input bit rdy);
    bit         pop_now, push_now;
    logic [4:0] g5;
    pop_now  = (m_q.size() > 0) && rdy;
    push_now = 1'b0;
    if (!rn) begin
      m_v1 = 0; m_v2 = 0; m_par = 0; m_gio = 0;
      m_fine = 0; m_vinc = 2'b00; m_ovf = 0; m_err = 0;
      m_q.delete(); in_match = 0; cmp_en = 1'b1;
    end else if (ini) begin
      m_v1 = 0; m_v2 = 0; m_par = 0; m_gio = 0;
      m_fine = 0; m_vinc = 2'b00; m_ovf = 0; m_err = 0;
      m_q.delete(); in_match = 1;
    end else begin
      m_fine = 0;
      if (in_match) begin
        if (m != 2'b00) begin
          if (m == 2'b01 && m_v1 < MAXC) m_v1++;
          if (m == 2'b10 && m_v2 < MAXC) m_v2++;
          if (m == 2'b11 && m_par < MAXC) m_par++;
          if (m_gio < MAXC) m_gio++;
          push_now = 1'b1;
        end
        if (p != 2'b00) begin
          m_vinc = p; m_fine = 1; in_match = 0;
          if ((p == 2'b01 && !(m_v1 > m_v2)) || (p == 2'b10 && !(m_v2 > m_v1)) ||
              (p == 2'b11 && m_v1 != m_v2)) m_err = 1;
        end
      end else if (m != 2'b00 || p != 2'b00) begin
        m_err = 1;
      end
      if (m_v1 == MAXC || m_v2 == MAXC || m_par == MAXC || m_gio == MAXC) m_err = 1;
      if (pop_now) void'(m_q.pop_front());
      if (push_now) begin
        g5 = m_gio[4:0];
        if (m_q.size() < DEPTH) m_q.push_back({g5, m});
        else m_ovf = 1;
      end
    end
  endtask

  // One clock of stimulus: drive, record an accepted pop, clock, advance model.
  task automatic cyc(input bit rn, input bit ini, input logic [1:0] m,
                     input logic [1:0] p, input bit rdy);
    RESET_N = rn; INIZIO = ini; MANCHE = m; PARTITA = p; LOG_READY = rdy;
    #1;
    if (rn && !ini && LOG_VALID && rdy) pops.push_back(LOG_DATA);
    @(posedge clk);
    model_update(rn, ini, m, p, rdy);
    #1;
  endtask

  logic [6:0] hd;
  always @(negedge clk) begin
    if (cmp_en) begin
      hd = (m_q.size() > 0) ? m_q[0] : 7'h00;
      chk("VINTE1", VINTE1, m_v1);
      chk("VINTE2", VINTE2, m_v2);
      chk("PAREGGI", PAREGGI, m_par);
      chk("GIOCATE", GIOCATE, m_gio);
      chk("FINE", FINE, m_fine);
      chk("VINCITORE", VINCITORE, m_vinc);
      chk("OVERFLOW", OVERFLOW, m_ovf);
      chk("ERRORE", ERRORE, m_err);
      chk("LOG_VALID", LOG_VALID, m_q.size() > 0);
      chk("LOG_DATA", LOG_DATA, hd);
    end
  end

  initial begin
    RESET_N = 1'b0; INIZIO = 1'b0; MANCHE = 2'b00; PARTITA = 2'b00; LOG_READY = 1'b0;

    // Reset, and INIZIO held under reset must leave the monitor idle.
    cyc(0, 0, 2'b00, 2'b00, 0);
    cyc(0, 0, 2'b00, 2'b00, 0);
    chk("t1_gio", GIOCATE, 0);
    chk("t1_valid", LOG_VALID, 0);
    chk("t1_err", ERRORE, 0);
    cyc(0, 1, 2'b00, 2'b00, 0);
    cyc(1, 0, 2'b01, 2'b00, 0);
    chk("t1_idle_v1", VINTE1, 0);
    chk("t1_idle_err", ERRORE, 1);

    // Basic match won by P1.
    cyc(1, 1, 2'b00, 2'b00, 0);
    chk("t2_err_clr", ERRORE, 0);
    pops.delete();
    cyc(1, 0, 2'b10, 2'b00, 0);
    cyc(1, 0, 2'b01, 2'b00, 0);
    cyc(1, 0, 2'b01, 2'b00, 0);
    cyc(1, 0, 2'b01, 2'b01, 0);
    chk("t2_v1", VINTE1, 3);
    chk("t2_v2", VINTE2, 1);
    chk("t2_gio", GIOCATE, 4);
    chk("t2_fine", FINE, 1);
    chk("t2_vinc", VINCITORE, 2'b01);
    chk("t2_err", ERRORE, 0);
    cyc(1, 0, 2'b00, 2'b00, 1);
    chk("t2_fine_pulse", FINE, 0);
    repeat (4) cyc(1, 0, 2'b00, 2'b00, 1);
    // {idx,code}: 1/10 -> 06, 2/01 -> 09, 3/01 -> 0D, 4/01 -> 11
    chk("t2_npops", pops.size(), 4);
    if (pops.size() == 4) begin
      chk("t2_pop0", pops[0], 7'h06);
      chk("t2_pop1", pops[1], 7'h09);
      chk("t2_pop2", pops[2], 7'h0D);
      chk("t2_pop3", pops[3], 7'h11);
    end

    // Declared winner disagrees with the tallies.
    cyc(1, 1, 2'b00, 2'b00, 0);
    cyc(1, 0, 2'b01, 2'b00, 0);
    cyc(1, 0, 2'b01, 2'b00, 0);
    cyc(1, 0, 2'b11, 2'b10, 0);
    chk("t3_par", PAREGGI, 1);
    chk("t3_vinc", VINCITORE, 2'b10);
    chk("t3_err", ERRORE, 1);

    // Overflow on a full log, then the same with a pop on the ninth push.
    cyc(1, 1, 2'b00, 2'b00, 0);
    pops.delete();
    repeat (9) cyc(1, 0, 2'b01, 2'b00, 0);
    chk("t4_gio", GIOCATE, 9);
    chk("t4_ovf", OVERFLOW, 1);
    repeat (9) cyc(1, 0, 2'b00, 2'b00, 1);
    chk("t4_npops", pops.size(), 8);
    foreach (pops[i]) chk("t4_idx", pops[i][6:2], i + 1);
    cyc(1, 1, 2'b00, 2'b00, 0);
    chk("t4_ovf_clr", OVERFLOW, 0);
    repeat (8) cyc(1, 0, 2'b01, 2'b00, 0);
    cyc(1, 0, 2'b01, 2'b00, 1);
    chk("t4b_ovf", OVERFLOW, 0);
    chk("t4b_gio", GIOCATE, 9);
    chk("t4b_head", LOG_DATA, 7'h09);

    // Post-match activity, then INIZIO flushing a pending pop.
    cyc(1, 0, 2'b00, 2'b01, 0);
    chk("t5_fine", FINE, 1);
    chk("t5_err0", ERRORE, 0);
    cyc(1, 0, 2'b01, 2'b00, 0);
    chk("t5_v1", VINTE1, 9);
    chk("t5_err1", ERRORE, 1);
    cyc(1, 1, 2'b00, 2'b00, 1);
    chk("t5_err_clr", ERRORE, 0);
    chk("t5_gio", GIOCATE, 0);
    chk("t5_valid", LOG_VALID, 0);

    // Push and ready together on an empty log: no fall-through.
    cyc(1, 0, 2'b01, 2'b00, 1);
    chk("ept_valid", LOG_VALID, 1);
    chk("ept_data", LOG_DATA, 7'h05);

    // Invalid rounds, then reset mid-match with a non-empty log.
    repeat (3) cyc(1, 0, 2'b00, 2'b00, 0);
    chk("t6_gio", GIOCATE, 1);
    chk("t6_err", ERRORE, 0);
    cyc(0, 0, 2'b01, 2'b00, 0);
    chk("t6_rst_gio", GIOCATE, 0);
    chk("t6_rst_v1", VINTE1, 0);
    chk("t6_rst_valid", LOG_VALID, 0);
    cyc(1, 0, 2'b01, 2'b00, 0);
    chk("t6_idle_err", ERRORE, 1);

    // Counter saturation.
    cyc(1, 1, 2'b00, 2'b00, 1);
    repeat (30) cyc(1, 0, 2'b11, 2'b00, 1);
    chk("sat_gio30", GIOCATE, 30);
    chk("sat_err0", ERRORE, 0);
    cyc(1, 0, 2'b11, 2'b00, 1);
    chk("sat_gio31", GIOCATE, 31);
    chk("sat_err1", ERRORE, 1);
    cyc(1, 0, 2'b11, 2'b00, 1);
    chk("sat_hold", PAREGGI, 31);
    cyc(1, 0, 2'b00, 2'b00, 1);
    cyc(1, 0, 2'b00, 2'b00, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
